// File: rtl/byte_rd_serializer_if.sv
// rtl/byte_rd_serializer_if.sv - load/output handshake bundle for byte_rd_serializer
interface byte_rd_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_byte;
    logic [1:0]            out_sel;
    logic                  out_last;
    logic                  busy;

    modport master (
        output load_valid, load_data, abort, out_ready,
        input  load_ready, out_valid, out_byte, out_sel, out_last, busy
    );

    modport slave (
        input  load_valid, load_data, abort, out_ready,
        output load_ready, out_valid, out_byte, out_sel, out_last, busy
    );
endinterface

// File: rtl/byte_rd_serializer.sv
// rtl/byte_rd_serializer.sv - splits a word into LSB-first bytes over a valid/ready stream
module byte_rd_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    byte_rd_serializer_if.slave     bus
);
    localparam int         NUM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q;
    logic [31:0] hold_q;
    logic [1:0]  idx_q;
    logic [7:0]  out_byte_q;
    logic [1:0]  out_sel_q;
    logic        out_last_q;

    logic [31:0] load_ext;
    logic [1:0]  idx_d;

    assign load_ext = 32'(bus.load_data);
    assign idx_d    = idx_q + 2'd1;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] s;
        s = w >> {i, 3'b000};
        return s[7:0];
    endfunction

    // Byte outputs are registered so out_ready never reaches them combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= 32'd0;
            idx_q      <= 2'd0;
            out_byte_q <= 8'd0;
            out_sel_q  <= 2'd0;
            out_last_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid && !bus.abort) begin
                        state_q    <= SEND;
                        hold_q     <= load_ext;
                        idx_q      <= 2'd0;
                        out_byte_q <= load_ext[7:0];
                        out_sel_q  <= 2'd0;
                        out_last_q <= (LAST_IDX == 2'd0);
                    end
                end
                SEND: begin
                    // Abort wins over a simultaneous handshake: that byte is dropped.
                    if (bus.abort || (bus.out_ready && out_last_q)) begin
                        state_q    <= IDLE;
                        idx_q      <= 2'd0;
                        out_byte_q <= 8'd0;
                        out_sel_q  <= 2'd0;
                        out_last_q <= 1'b0;
                    end else if (bus.out_ready) begin
                        idx_q      <= idx_d;
                        out_byte_q <= pick_byte(hold_q, idx_d);
                        out_sel_q  <= idx_d;
                        out_last_q <= (idx_d == LAST_IDX);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = (state_q == IDLE) && !bus.abort;
    assign bus.out_valid  = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.out_byte   = out_byte_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.out_last   = out_last_q;
endmodule

// File: tb/tb_byte_rd_serializer.sv
// tb/tb_byte_rd_serializer.sv - scoreboard bench for byte_rd_serializer at widths 32, 12 and 1
module tb_byte_rd_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_rd_serializer_if #(.DATA_WIDTH(32)) if32 ();
    byte_rd_serializer_if #(.DATA_WIDTH(12)) if12 ();
    byte_rd_serializer_if #(.DATA_WIDTH(1))  if1  ();

    byte_rd_serializer #(.DATA_WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
    byte_rd_serializer #(.DATA_WIDTH(12)) u12 (.clk(clk), .rst(rst), .bus(if12));
    byte_rd_serializer #(.DATA_WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int errors = 0;

    // Expected entries are {byte, sel, last}.
    logic [10:0] exp32[$];
    logic [10:0] exp12[$];
    logic [10:0] exp1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if32.out_valid && !if32.abort) begin
            if (if32.out_ready) begin
                if (exp32.size() == 0) chk("u32 unexpected byte", {21'd0, if32.out_byte, if32.out_sel, if32.out_last}, 32'h7ff);
                else chk("u32 byte", {21'd0, if32.out_byte, if32.out_sel, if32.out_last}, {21'd0, exp32.pop_front()});
            end else if (exp32.size() != 0) begin
                chk("u32 stalled byte", {21'd0, if32.out_byte, if32.out_sel, if32.out_last}, {21'd0, exp32[0]});
            end
        end
        if (!rst && if12.out_valid && if12.out_ready && !if12.abort) begin
            if (exp12.size() == 0) chk("u12 unexpected byte", {21'd0, if12.out_byte, if12.out_sel, if12.out_last}, 32'h7ff);
            else chk("u12 byte", {21'd0, if12.out_byte, if12.out_sel, if12.out_last}, {21'd0, exp12.pop_front()});
        end
        if (!rst && if1.out_valid && if1.out_ready && !if1.abort) begin
            if (exp1.size() == 0) chk("u1 unexpected byte", {21'd0, if1.out_byte, if1.out_sel, if1.out_last}, 32'h7ff);
            else chk("u1 byte", {21'd0, if1.out_byte, if1.out_sel, if1.out_last}, {21'd0, exp1.pop_front()});
        end
    end

    task automatic push32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp32.push_back({w[i*8 +: 8], 2'(i), (i == 3)});
    endtask

    // Entered at posedge+1; leaves at posedge+1 after the load edge.
    task automatic load32(input logic [31:0] w);
        if32.load_valid = 1'b1;
        if32.load_data  = w;
        chk("load_ready before load", {31'd0, if32.load_ready}, 32'd1);
        @(posedge clk); #1;
        if32.load_valid = 1'b0;
        chk("out_valid one cycle after load", {31'd0, if32.out_valid}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp32.size() + exp12.size() + exp1.size()) != 0 && n < 64) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("scoreboard drained", 32'(exp32.size() + exp12.size() + exp1.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        bit done;
        pat = 4'b1001;
        if32.load_valid = 0; if32.load_data = '0; if32.abort = 0; if32.out_ready = 1;
        if12.load_valid = 0; if12.load_data = '0; if12.abort = 0; if12.out_ready = 1;
        if1.load_valid  = 0; if1.load_data  = '0; if1.abort  = 0; if1.out_ready  = 1;
        #2;
        chk("reset out_valid", {31'd0, if32.out_valid}, 32'd0);
        chk("reset busy", {31'd0, if32.busy}, 32'd0);
        chk("reset out_byte", {24'd0, if32.out_byte}, 32'd0);
        chk("reset out_sel", {30'd0, if32.out_sel}, 32'd0);
        chk("reset out_last", {31'd0, if32.out_last}, 32'd0);
        chk("reset load_ready", {31'd0, if32.load_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Full-rate word, then one idle cycle before the next load.
        push32(32'hA1B2C3D4);
        load32(32'hA1B2C3D4);
        repeat (3) @(posedge clk);
        #1 chk("busy on last byte", {31'd0, if32.busy}, 32'd1);
        @(posedge clk); #1;
        chk("load_ready after word", {31'd0, if32.load_ready}, 32'd1);
        chk("busy after word", {31'd0, if32.busy}, 32'd0);
        drain();

        // Stalled consumer with load bus changing during SEND.
        push32(32'hA1B2C3D4);
        load32(32'hA1B2C3D4);
        if32.load_data  = 32'hFFFFFFFF;
        if32.load_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            if32.out_ready = pat[3 - (i % 4)];
            if (i == 2) if32.load_valid = 1'b0;
            @(posedge clk); #1;
            if (!if32.busy) done = 1'b1;
        end
        chk("stall sequence finished", {31'd0, done}, 32'd1);
        if32.out_ready = 1'b1;
        drain();

        // Narrow widths.
        exp12.push_back({8'hAB, 2'd0, 1'b0});
        exp12.push_back({8'h0F, 2'd1, 1'b1});
        exp1.push_back({8'h01, 2'd0, 1'b1});
        if12.load_valid = 1'b1; if12.load_data = 12'hFAB;
        if1.load_valid  = 1'b1; if1.load_data  = 1'b1;
        @(posedge clk); #1;
        if12.load_valid = 1'b0; if1.load_valid = 1'b0;
        chk("u12 out_valid after load", {31'd0, if12.out_valid}, 32'd1);
        chk("u1 out_last", {31'd0, if1.out_last}, 32'd1);
        drain();

        // Abort on byte 33 together with out_ready.
        exp32.push_back({8'h44, 2'd0, 1'b0});
        load32(32'h11223344);
        @(posedge clk); #1;
        chk("byte 33 presented", {24'd0, if32.out_byte}, 32'h33);
        if32.abort = 1'b1;
        @(posedge clk); #1;
        if32.abort = 1'b0;
        chk("busy after abort", {31'd0, if32.busy}, 32'd0);
        chk("out_valid after abort", {31'd0, if32.out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        push32(32'h55667788);
        load32(32'h55667788);
        drain();

        // Asynchronous reset while byte 22 is presented.
        exp32.push_back({8'h44, 2'd0, 1'b0});
        exp32.push_back({8'h33, 2'd1, 1'b0});
        load32(32'h11223344);
        repeat (2) @(posedge clk);
        #1 if32.out_ready = 1'b0;
        chk("byte 22 presented", {24'd0, if32.out_byte}, 32'h22);
        #2 rst = 1'b1;
        #1;
        chk("out_valid in async reset", {31'd0, if32.out_valid}, 32'd0);
        chk("busy in async reset", {31'd0, if32.busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset release", {31'd0, if32.out_valid}, 32'd0);
        push32(32'h01020304);
        load32(32'h01020304);
        drain();

        // Abort with load_valid while idle.
        if32.abort = 1'b1;
        if32.load_valid = 1'b1;
        if32.load_data = 32'hDEADBEEF;
        #1 chk("load_ready under abort", {31'd0, if32.load_ready}, 32'd0);
        @(posedge clk); #1;
        chk("busy after idle abort", {31'd0, if32.busy}, 32'd0);
        chk("out_valid after idle abort", {31'd0, if32.out_valid}, 32'd0);
        if32.abort = 1'b0;
        if32.load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_rd_serializer.md
BYTE_RD_SERIALIZER -- requirements
Module: byte_rd_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the word to serialize (legal range 1..32).
REQ-002 SHALL have parameter NUM_BYTES, derived as ceil(DATA_WIDTH/8), meaning the bytes emitted per word (1..4); not overridable.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port load_valid, input, 1 bit: word offered on load_data.
REQ-006 SHALL have port load_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port load_data, input, DATA_WIDTH bits: word to serialize.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of current word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_byte/out_sel/out_last are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the byte.
REQ-011 SHALL have port out_byte, output, 8 bits: current byte.
REQ-012 SHALL have port out_sel, output, 2 bits: byte index of out_byte (0 = bits 7:0).
REQ-013 SHALL have port out_last, output, 1 bit: out_byte is the final byte of the word.
REQ-014 SHALL have port busy, output, 1 bit: a word is held (state SEND).

Function
REQ-015 SHALL implement two states: IDLE and SEND.
REQ-016 In IDLE: load_ready = !abort; out_valid = 0; busy = 0.
REQ-017 On edge with IDLE && load_valid && load_ready: capture load_data zero-extended to 32 bits into a holding register, set index to 0, go to SEND.
REQ-018 out_valid SHALL be 1 on the first cycle after the load edge (load-to-first-byte latency = 1 cycle).
REQ-019 In SEND: load_ready = 0; out_valid = 1; busy = 1; out_byte = holding[index*8 +: 8]; out_sel = index; out_last = (index == NUM_BYTES-1).
REQ-020 Bits above DATA_WIDTH in the final byte SHALL read as 0.
REQ-021 On an edge with out_valid && out_ready && !out_last: index increments by 1; state remains SEND.
REQ-022 On an edge with out_valid && out_ready && out_last: go to IDLE; load_ready = 1 on the following cycle (one idle cycle between words, no back-to-back overlap).
REQ-023 While out_valid && !out_ready: out_byte, out_sel and out_last SHALL stay stable.
REQ-024 Holding register SHALL NOT change in SEND regardless of load_valid/load_data.
REQ-025 abort=1 in SEND: next edge goes to IDLE, remaining bytes dropped, index cleared; abort takes priority over a simultaneous out_ready handshake (that byte counts as not transferred).
REQ-026 abort=1 in IDLE: no state change; load_valid ignored that cycle (load_ready = 0).
REQ-027 NUM_BYTES = 1: the single byte has out_sel = 0 and out_last = 1.
REQ-028 Outputs SHALL be driven from registers or state decode only; there SHALL be no combinational path from out_ready to out_valid/out_byte.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, index = 0, holding register = 0; out_valid = 0, busy = 0, out_byte = 0, out_sel = 0, out_last = 0, load_ready = 1 (if abort = 0).
REQ-030 rst asserted mid-word SHALL discard the word; after release no byte of it is emitted and the next load is accepted normally.

Verification
REQ-031 DATA_WIDTH=32, load 0xA1B2C3D4, out_ready=1 -> bytes D4,C3,B2,A1 with out_sel 0,1,2,3 on 4 consecutive cycles, out_last only with A1, load_ready=1 one cycle later.
REQ-032 Same load, out_ready toggling 1,0,0,1,... -> each byte held stable while stalled; sequence unchanged; load_data changed to 0xFFFFFFFF during SEND has no effect.
REQ-033 DATA_WIDTH=12, load 0xFAB -> bytes AB then 0F, out_last on 0F; DATA_WIDTH=1, load 1 -> single byte 01, out_sel=0, out_last=1.
REQ-034 Load 0x11223344, accept 44, assert abort together with out_ready on byte 33 -> IDLE next cycle, no further bytes; next load 0x55667788 emits 88 first with out_sel=0.
REQ-035 Async rst pulse between clock edges while byte 22 is presented -> out_valid=0 and busy=0 immediately; after release, load 0x01020304 emits 04,03,02,01.
REQ-036 abort=1 and load_valid=1 together in IDLE -> load_ready=0, word not captured, busy stays 0.
